sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_if.sv | 38 +++
 rtl/sram_arbiter.sv | 137 +++++++++++++
 tb/tb_sram_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Bus bundle between the SNES/AVR requesters, the SRAM arbiter and the SRAM.
// The arbiter uses the slave modport; requesters plus the SRAM use master.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 21
);
  // SNES read-only port
  logic              snes_req;
  logic [ADDR_W-1:0] snes_addr;
  logic              snes_ack;
  logic [7:0]        snes_rdata;
  // AVR read/write port
  logic              avr_req;
  logic              avr_we;
  logic [ADDR_W-1:0] avr_addr;
  logic [7:0]        avr_wdata;
  logic              avr_ack;
  logic [7:0]        avr_rdata;
  // SRAM side, data bus split; the chip top builds the tristate from sram_dout_en
  logic [ADDR_W-1:0] sram_addr;
  logic [7:0]        sram_dout;
  logic              sram_dout_en;
  logic [7:0]        sram_din;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;

  modport slave (
    input  snes_req, snes_addr, avr_req, avr_we, avr_addr, avr_wdata, sram_din,
    output snes_ack, snes_rdata, avr_ack, avr_rdata,
    output sram_addr, sram_dout, sram_dout_en, sram_ce_n, sram_oe_n, sram_we_n
  );

  modport master (
    output snes_req, snes_addr, avr_req, avr_we, avr_addr, avr_wdata, sram_din,
    input  snes_ack, snes_rdata, avr_ack, avr_rdata,
    input  sram_addr, sram_dout, sram_dout_en, sram_ce_n, sram_oe_n, sram_we_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-master asynchronous SRAM arbiter. SNES (read-only) has absolute priority
// while snes_mode=1; the AVR gets the bus otherwise. Each transaction walks
// IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles) -> DONE -> IDLE, and every
// output comes straight from a register.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2,   // legal 1..15
  parameter int unsigned ADDR_W      = 21
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              snes_mode,
  output logic [1:0]        state,
  sram_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  // ACCESS lasts WAIT_CYCLES cycles: load N-1 and leave when the count is 0
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_we;          // latched direction of the granted transaction
  logic              r_gnt_snes;    // latched owner of the granted transaction
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_dout;
  logic              r_dout_en;
  logic              r_ce_n;
  logic              r_oe_n;
  logic              r_we_n;
  logic              r_snes_ack;
  logic              r_avr_ack;
  logic [7:0]        r_snes_rdata;
  logic [7:0]        r_avr_rdata;

  // Arbitration, transaction sequencing and all registered SRAM/requester outputs
  // NOTE: every state element here uses <= so all registers update together at
  // the edge; mixing in = would make results depend on statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: this block holds only control/data registers (no memory array), so
    // every one of them is cleared by reset to give deterministic bus strobes.
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_gnt_snes   <= 1'b0;
      r_addr       <= '0;
      r_dout       <= 8'h00;
      r_dout_en    <= 1'b0;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_snes_ack   <= 1'b0;
      r_avr_ack    <= 1'b0;
      r_snes_rdata <= 8'h00;
      r_avr_rdata  <= 8'h00;
    end else begin
      // Acks are single-cycle pulses; only the ACCESS exit raises them
      r_snes_ack <= 1'b0;
      r_avr_ack  <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          // Requester inputs are sampled only here; everything after runs
          // from the latched copies so dropped requests still complete.
          if (snes_mode && bus.snes_req) begin
            r_gnt_snes <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= bus.snes_addr;
            r_dout_en  <= 1'b0;
            r_ce_n     <= 1'b0;
            r_oe_n     <= 1'b0;
            r_state    <= ST_SETUP;
          end else if (bus.avr_req) begin
            r_gnt_snes <= 1'b0;
            r_we       <= bus.avr_we;
            r_addr     <= bus.avr_addr;
            r_dout     <= bus.avr_wdata;
            r_dout_en  <= bus.avr_we;
            r_ce_n     <= 1'b0;
            r_oe_n     <= bus.avr_we;    // reads enable the output from SETUP
            r_state    <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          r_cnt   <= CNT_LOAD;
          r_we_n  <= ~r_we;              // write strobe covers ACCESS only
          r_state <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_state <= ST_DONE;
            // Read data is captured at the edge closing the last ACCESS cycle
            if (!r_we) begin
              if (r_gnt_snes) r_snes_rdata <= bus.sram_din;
              else            r_avr_rdata  <= bus.sram_din;
            end
            if (r_gnt_snes) r_snes_ack <= 1'b1;
            else            r_avr_ack  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        ST_DONE: begin
          r_ce_n    <= 1'b1;
          r_dout_en <= 1'b0;
          r_state   <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign state            = r_state;
  assign bus.sram_addr    = r_addr;
  assign bus.sram_dout    = r_dout;
  assign bus.sram_dout_en = r_dout_en;
  assign bus.sram_ce_n    = r_ce_n;
  assign bus.sram_oe_n    = r_oe_n;
  assign bus.sram_we_n    = r_we_n;
  assign bus.snes_ack     = r_snes_ack;
  assign bus.snes_rdata   = r_snes_rdata;
  assign bus.avr_ack      = r_avr_ack;
  assign bus.avr_rdata    = r_avr_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter. Expected behaviour comes from the
// cycle-offset rules of a transaction (grant at offset 0, DONE at W+2) and a
// sparse reference memory; an SRAM model backs the main instance.
module tb_sram_arbiter;

  localparam int W = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       snes_mode;
  logic [1:0] state, state_w1, state_w15;

  int n_checks = 0;
  int n_errors = 0;

  sram_arbiter_if #(.ADDR_W(21)) bus ();
  sram_arbiter_if #(.ADDR_W(21)) if_w1 ();
  sram_arbiter_if #(.ADDR_W(21)) if_w15 ();

  sram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(21)) dut (
    .clk(clk), .reset_n(reset_n), .snes_mode(snes_mode), .state(state), .bus(bus.slave));
  sram_arbiter #(.WAIT_CYCLES(1), .ADDR_W(21)) dut_w1 (
    .clk(clk), .reset_n(reset_n), .snes_mode(snes_mode), .state(state_w1), .bus(if_w1.slave));
  sram_arbiter #(.WAIT_CYCLES(15), .ADDR_W(21)) dut_w15 (
    .clk(clk), .reset_n(reset_n), .snes_mode(snes_mode), .state(state_w15), .bus(if_w15.slave));

  always #5 clk = ~clk;

  // SRAM device model for the main instance (1K deep, indexed by addr[9:0])
  logic [7:0] mem [0:1023];
  assign bus.sram_din = mem[bus.sram_addr[9:0]];
  always @(posedge clk)
    if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dout_en)
      mem[bus.sram_addr[9:0]] <= bus.sram_dout;

  // The timing-only instances read a fixed function of the address
  assign if_w1.sram_din  = if_w1.sram_addr[7:0] ^ 8'hA5;
  assign if_w15.sram_din = if_w15.sram_addr[7:0] ^ 8'hA5;

  // Reference model state
  logic [7:0]  ref_mem [logic [20:0]];
  logic [7:0]  exp_snes_rd, exp_avr_rd;
  logic [20:0] pool [8];

  function automatic logic [7:0] ref_rd(input logic [20:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Strobe exclusivity on every instance, every cycle outside reset
  always @(negedge clk) begin
    if (reset_n) begin
      n_checks++;
      if ((!bus.sram_oe_n && !bus.sram_we_n) || (bus.sram_dout_en && !bus.sram_oe_n)) begin
        n_errors++;
        $display("FAIL excl_main t=%0t oe_n=%b we_n=%b dout_en=%b", $time,
                 bus.sram_oe_n, bus.sram_we_n, bus.sram_dout_en);
      end
      n_checks++;
      if ((!if_w1.sram_oe_n && !if_w1.sram_we_n) || (if_w1.sram_dout_en && !if_w1.sram_oe_n)) begin
        n_errors++;
        $display("FAIL excl_w1 t=%0t oe_n=%b we_n=%b dout_en=%b", $time,
                 if_w1.sram_oe_n, if_w1.sram_we_n, if_w1.sram_dout_en);
      end
      n_checks++;
      if ((!if_w15.sram_oe_n && !if_w15.sram_we_n) || (if_w15.sram_dout_en && !if_w15.sram_oe_n)) begin
        n_errors++;
        $display("FAIL excl_w15 t=%0t oe_n=%b we_n=%b dout_en=%b", $time,
                 if_w15.sram_oe_n, if_w15.sram_we_n, if_w15.sram_dout_en);
      end
    end
  end

  // One full transaction on the main instance, started at a negedge while IDLE.
  // Checks the whole strobe/ack/address waveform by offset k from the grant cycle.
  task automatic run_txn(input bit snes, input bit we, input logic [20:0] a,
                         input logic [7:0] d, input string tag);
    logic [7:0]  rd_new;
    logic [1:0]  es;
    logic [29:0] obs, exp_v;
    logic [7:0]  e_srd, e_ard;
    rd_new = ref_rd(a);
    if (snes) begin
      bus.snes_addr = a; bus.snes_req = 1'b1;
    end else begin
      bus.avr_addr = a; bus.avr_we = we; bus.avr_wdata = d; bus.avr_req = 1'b1;
    end
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      es = (k == 1) ? 2'b01 : (k <= W + 1) ? 2'b10 : (k == W + 2) ? 2'b11 : 2'b00;
      exp_v = {es, 1'(k >= W + 3), 1'(!(!we && k <= W + 1)),
               1'(!(we && k >= 2 && k <= W + 1)), 1'(we && k <= W + 2),
               1'(snes && k == W + 2), 1'(!snes && k == W + 2), a};
      obs = {state, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dout_en,
             bus.snes_ack, bus.avr_ack, bus.sram_addr};
      n_checks++;
      if (obs !== exp_v) begin
        n_errors++;
        $display("FAIL %s wave k=%0d got {st,ce,oe,we,den,sack,aack,addr}=%h exp %h",
                 tag, k, obs, exp_v);
      end
      if (we && k <= W + 2) begin
        n_checks++;
        if (bus.sram_dout !== d) begin
          n_errors++;
          $display("FAIL %s dout k=%0d got %h exp %h", tag, k, bus.sram_dout, d);
        end
      end
      e_srd = (snes && k >= W + 2) ? rd_new : exp_snes_rd;
      e_ard = (!snes && !we && k >= W + 2) ? rd_new : exp_avr_rd;
      n_checks++;
      if (bus.snes_rdata !== e_srd || bus.avr_rdata !== e_ard) begin
        n_errors++;
        $display("FAIL %s rdata k=%0d got snes=%h avr=%h exp snes=%h avr=%h",
                 tag, k, bus.snes_rdata, bus.avr_rdata, e_srd, e_ard);
      end
      if (k == W + 2) begin
        bus.snes_req = 1'b0; bus.avr_req = 1'b0;
      end
    end
    if (snes)     exp_snes_rd = rd_new;
    else if (!we) exp_avr_rd  = rd_new;
    else begin
      ref_mem[a] = d;
      n_checks++;
      if (mem[a[9:0]] !== d) begin
        n_errors++;
        $display("FAIL %s sram_mem got %h exp %h", tag, mem[a[9:0]], d);
      end
    end
  endtask

  // SNES request with snes_mode=0 must be ignored entirely
  task automatic snes_ignored(input logic [20:0] a, input int cycles);
    snes_mode = 1'b0; bus.snes_addr = a; bus.snes_req = 1'b1;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      n_checks++;
      if (state !== 2'b00 || bus.snes_ack !== 1'b0 || bus.sram_ce_n !== 1'b1) begin
        n_errors++;
        $display("FAIL snes_ignored k=%0d got st=%0d sack=%b ce_n=%b exp 0 0 1",
                 k, state, bus.snes_ack, bus.sram_ce_n);
      end
    end
    bus.snes_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [50:0] obs;
    @(negedge clk);
    obs = {state, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dout_en,
           bus.sram_addr, bus.sram_dout, bus.snes_ack, bus.avr_ack,
           bus.snes_rdata, bus.avr_rdata};
    n_checks++;
    if (obs !== {2'b00, 3'b111, 1'b0, 21'h0, 8'h00, 2'b00, 16'h0000}) begin
      n_errors++;
      $display("FAIL reset_values got %h exp %h", obs,
               {2'b00, 3'b111, 1'b0, 21'h0, 8'h00, 2'b00, 16'h0000});
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (state !== 2'b00 || state_w1 !== 2'b00 || state_w15 !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_idle got %0d %0d %0d exp 0 0 0", state, state_w1, state_w15);
    end
  endtask

  task automatic test_write_read();
    snes_mode = 1'b0;
    run_txn(1'b0, 1'b1, 21'h012345, 8'h5A, "avr_write");
    run_txn(1'b0, 1'b0, 21'h012345, 8'h00, "avr_read");
  endtask

  task automatic test_contention();
    logic [20:0] sa, aa;
    sa = pool[1]; aa = pool[2];
    snes_mode = 1'b1;
    bus.snes_addr = sa; bus.snes_req = 1'b1;
    bus.avr_addr = aa; bus.avr_we = 1'b0; bus.avr_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.snes_ack !== 1'(k == W + 2) || bus.avr_ack !== 1'(k == 2 * W + 5)) begin
        n_errors++;
        $display("FAIL contention_ack k=%0d got sack=%b aack=%b exp %b %b", k,
                 bus.snes_ack, bus.avr_ack, 1'(k == W + 2), 1'(k == 2 * W + 5));
      end
      if (k == W + 2) begin
        n_checks++;
        if (bus.snes_rdata !== ref_rd(sa)) begin
          n_errors++;
          $display("FAIL contention_srd got %h exp %h", bus.snes_rdata, ref_rd(sa));
        end
        bus.snes_req = 1'b0;
      end
      if (k == 2 * W + 5) begin
        n_checks++;
        if (bus.avr_rdata !== ref_rd(aa)) begin
          n_errors++;
          $display("FAIL contention_ard got %h exp %h", bus.avr_rdata, ref_rd(aa));
        end
        bus.avr_req = 1'b0;
      end
    end
    exp_snes_rd = ref_rd(sa); exp_avr_rd = ref_rd(aa);
  endtask

  // Requests dropped right after grant, and a mode flip mid-transaction
  task automatic test_drop_and_mode();
    for (int t = 0; t < 2; t++) begin
      snes_mode = 1'b1;
      if (t == 0) begin
        bus.snes_addr = pool[3]; bus.snes_req = 1'b1;
      end else begin
        bus.avr_addr = pool[4]; bus.avr_we = 1'b0; bus.avr_req = 1'b1;
      end
      for (int k = 1; k <= W + 3; k++) begin
        @(negedge clk);
        if (k == 1) begin
          bus.snes_req = 1'b0; bus.avr_req = 1'b0; snes_mode = 1'b0;
        end
        if (k >= W + 2) begin
          n_checks++;
          if (bus.snes_ack !== 1'(t == 0 && k == W + 2) ||
              bus.avr_ack !== 1'(t == 1 && k == W + 2) ||
              state !== ((k == W + 2) ? 2'b11 : 2'b00)) begin
            n_errors++;
            $display("FAIL drop_mode t=%0d k=%0d got sack=%b aack=%b st=%0d", t, k,
                     bus.snes_ack, bus.avr_ack, state);
          end
        end
      end
      if (t == 0) exp_snes_rd = ref_rd(pool[3]);
      else        exp_avr_rd  = ref_rd(pool[4]);
      n_checks++;
      if (bus.snes_rdata !== exp_snes_rd || bus.avr_rdata !== exp_avr_rd) begin
        n_errors++;
        $display("FAIL drop_mode_rd t=%0d got %h %h exp %h %h", t, bus.snes_rdata,
                 bus.avr_rdata, exp_snes_rd, exp_avr_rd);
      end
    end
  endtask

  task automatic test_random();
    int sel;
    for (int i = 0; i < 24; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: begin snes_mode = 1'b1;
                 run_txn(1'b1, 1'b0, pool[$urandom_range(0, 7)], 8'h00, "rand_snes"); end
        1: snes_ignored(pool[$urandom_range(0, 7)], W + 4);
        2: begin snes_mode = 1'($urandom_range(0, 1));
                 run_txn(1'b0, 1'b1, pool[$urandom_range(0, 7)], 8'($urandom), "rand_wr"); end
        default: begin snes_mode = 1'($urandom_range(0, 1));
                 run_txn(1'b0, 1'b0, pool[$urandom_range(0, 7)], 8'h00, "rand_rd"); end
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    snes_mode = 1'b0;
    bus.avr_addr = pool[5]; bus.avr_we = 1'b1; bus.avr_wdata = 8'hC3; bus.avr_req = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (state !== 2'b10 || bus.sram_we_n !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_pre got st=%0d we_n=%b exp 2 0", state, bus.sram_we_n);
    end
    reset_n = 1'b0; bus.avr_req = 1'b0;
    #1;
    n_checks++;
    if ({state, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dout_en,
         bus.avr_ack} !== 7'b00_111_0_0) begin
      n_errors++;
      $display("FAIL reset_mid_async got st=%0d ce=%b oe=%b we=%b den=%b aack=%b",
               state, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n,
               bus.sram_dout_en, bus.avr_ack);
    end
    exp_snes_rd = 8'h00; exp_avr_rd = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.avr_ack !== 1'b0 || state !== 2'b00) begin
        n_errors++;
        $display("FAIL reset_mid_noack k=%0d got aack=%b st=%0d", k, bus.avr_ack, state);
      end
    end
    run_txn(1'b0, 1'b0, pool[5], 8'h00, "after_reset_rd");
    run_txn(1'b0, 1'b1, pool[5], 8'h3C, "after_reset_wr");
  endtask

  // Continuous AVR reads on the WAIT_CYCLES=1 / 15 instances: ack spacing W+3
  task automatic test_back_to_back(input int w);
    int          acks[$];
    logic [20:0] a;
    logic        ack;
    logic [7:0]  rd;
    a = 21'($urandom);
    if (w == 1) begin if_w1.avr_addr = a;  if_w1.avr_we = 1'b0;  if_w1.avr_req = 1'b1; end
    else        begin if_w15.avr_addr = a; if_w15.avr_we = 1'b0; if_w15.avr_req = 1'b1; end
    for (int c = 1; c <= 6 * (w + 3) + 4 && acks.size() < 5; c++) begin
      @(negedge clk);
      ack = (w == 1) ? if_w1.avr_ack : if_w15.avr_ack;
      rd  = (w == 1) ? if_w1.avr_rdata : if_w15.avr_rdata;
      if (ack) begin
        acks.push_back(c);
        n_checks++;
        if (rd !== (a[7:0] ^ 8'hA5)) begin
          n_errors++;
          $display("FAIL b2b_w%0d rdata got %h exp %h", w, rd, a[7:0] ^ 8'hA5);
        end
      end
    end
    if_w1.avr_req = 1'b0; if_w15.avr_req = 1'b0;
    n_checks++;
    if (acks.size() < 5) begin
      n_errors++;
      $display("FAIL b2b_w%0d timeout got %0d acks exp 5", w, acks.size());
    end else begin
      n_checks++;
      if (acks[0] != w + 2) begin
        n_errors++;
        $display("FAIL b2b_w%0d first_ack got %0d exp %0d", w, acks[0], w + 2);
      end
      for (int i = 1; i < acks.size(); i++) begin
        n_checks++;
        if (acks[i] - acks[i-1] != w + 3) begin
          n_errors++;
          $display("FAIL b2b_w%0d spacing got %0d exp %0d", w, acks[i] - acks[i-1], w + 3);
        end
      end
    end
    repeat (w + 4) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; snes_mode = 1'b0;
    bus.snes_req = 1'b0; bus.snes_addr = '0; bus.avr_req = 1'b0; bus.avr_we = 1'b0;
    bus.avr_addr = '0; bus.avr_wdata = 8'h00;
    if_w1.snes_req = 1'b0; if_w1.snes_addr = '0; if_w1.avr_req = 1'b0; if_w1.avr_we = 1'b0;
    if_w1.avr_addr = '0; if_w1.avr_wdata = 8'h00;
    if_w15.snes_req = 1'b0; if_w15.snes_addr = '0; if_w15.avr_req = 1'b0; if_w15.avr_we = 1'b0;
    if_w15.avr_addr = '0; if_w15.avr_wdata = 8'h00;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) pool[i] = {11'($urandom), 10'(i * 8 + 1)};
    exp_snes_rd = 8'h00; exp_avr_rd = 8'h00;

    test_reset();
    test_write_read();
    snes_ignored(pool[0], 8);
    test_contention();
    test_drop_and_mode();
    test_random();
    test_reset_mid();
    test_back_to_back(1);
    test_back_to_back(15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
